// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory: access size codes,
// controller state type and the value loaded into every word during the init sweep.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_INIT_VAL = 32'h8000_00FF;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: steers right-aligned store data onto byte lanes with
// matching byte enables, and extracts/extends the addressed lanes of a read word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Replicating the store data puts it on every lane; the enables pick the real ones.
  always_comb begin
    shifted = rword >> {lane, 3'b000};
    be      = 4'b0000;
    wword   = 32'h0;
    rdata   = 32'h0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        rdata = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_be.sv
// Word-organised data memory with byte/half/word loads and stores, a one-cycle
// registered response, and a power-on sweep that fills every word with INIT_VAL.
module data_mem_be
  import dmem_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] INIT_VAL = DEFAULT_INIT_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int IW = $clog2(DEPTH);

  state_e          state;
  logic [IW-1:0]   init_cnt;
  logic [31:0]     mem [DEPTH];
  logic            accept;
  logic            err;
  logic [IW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wword;
  logic [31:0]     ld_data;

  assign req_ready = ~init_busy;
  assign accept    = req_valid & req_ready;
  assign idx       = req_addr[IW+1:2];

  // Any set address bit above the word index means the access falls outside the array.
  always_comb begin
    case (req_size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = req_addr[0];
      SZ_WORD: err = |req_addr[1:0];
      default: err = 1'b1;
    endcase
    if ((req_addr >> (IW + 2)) != '0) err = 1'b1;
  end

  dmem_lane_align u_align (
    .size     (req_size),
    .lane     (req_addr[1:0]),
    .zero_ext (req_unsigned),
    .wdata    (req_wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[init_cnt] <= INIT_VAL;
      end else if (accept && req_we && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_busy <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt  <= init_cnt + 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          if (init_cnt == IW'(DEPTH - 1)) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
          rsp_valid <= accept;
          rsp_err   <= accept & err;
          rsp_rdata <= (accept && !err && !req_we) ? ld_data : 32'h0;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_be.sv
// Bench for data_mem_be: a byte-addressed reference model checked every cycle,
// plus directed transactions whose responses are pinned to hand-computed values.
module tb_data_mem_be;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_be #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_VAL(32'h8000_00FF)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_busy    (init_busy)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a little-endian byte array, init as a cycle countdown.
  logic [7:0]  mbytes [4*DEPTH];
  logic [31:0] initv = 32'h8000_00FF;
  int          busy_left = DEPTH;
  bit          armed = 0;
  logic        e_valid = 0;
  logic        e_err = 0;
  logic [31:0] e_rdata = 0;

  always @(posedge clk) begin
    int unsigned a;
    int nb;
    logic [31:0] v;
    if (rst) begin
      busy_left = DEPTH;
      armed = 1;
      e_valid = 0; e_err = 0; e_rdata = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      e_valid = 0; e_err = 0; e_rdata = 0;
      if (busy_left == 0)
        for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'((initv >> (8*(i % 4))) & 32'hFF);
    end else begin
      e_valid = req_valid; e_err = 0; e_rdata = 0;
      if (req_valid) begin
        a  = req_addr;
        nb = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        if (req_size == 2'd3 || (a % nb) != 0 || a >= 4*DEPTH) begin
          e_err = 1;
        end else if (req_we) begin
          for (int k = 0; k < nb; k++) mbytes[a+k] = req_wdata[8*k +: 8];
        end else begin
          v = 0;
          for (int k = 0; k < nb; k++) v = v | (32'(mbytes[a+k]) << (8*k));
          if (!req_unsigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
          e_rdata = v;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_valid});
      checkOutput("rsp_err",   {31'b0, rsp_err},   {31'b0, e_err});
      checkOutput("rsp_rdata", rsp_rdata, e_rdata);
      checkOutput("init_busy", {31'b0, init_busy}, {31'b0, busy_left > 0});
      checkOutput("req_ready", {31'b0, req_ready}, {31'b0, busy_left == 0});
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 0; req_we = 0; req_size = 2'b00; req_unsigned = 0;
    req_addr = '0; req_wdata = '0;
  endtask

  task automatic checkLit(input string name, input logic v, input logic [31:0] d, input logic e);
    checkOutput({name, ".valid"}, {31'b0, rsp_valid}, {31'b0, v});
    checkOutput({name, ".rdata"}, rsp_rdata, d);
    checkOutput({name, ".err"},   {31'b0, rsp_err},   {31'b0, e});
  endtask

  task automatic measureInit(input string name);
    int n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, 32'(n), 32'd64);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = '0; req_wdata = '0;
    @(negedge clk);
    rst = 0;
    measureInit("init_len");

    applyStimulus(0, SZ_WORD, 0, 32'h0FC, 0); idle();
    checkLit("ld_0fc", 1, 32'h8000_00FF, 0);

    applyStimulus(1, SZ_WORD, 0, 32'h10, 32'h1122_3344);
    applyStimulus(1, SZ_BYTE, 0, 32'h11, 32'h0000_00AA);
    applyStimulus(0, SZ_WORD, 0, 32'h10, 0); idle();
    checkLit("merge_10", 1, 32'h1122_AA44, 0);

    applyStimulus(1, SZ_WORD, 0, 32'h20, 32'h0000_80F0);
    applyStimulus(0, SZ_BYTE, 0, 32'h20, 0); idle();
    checkLit("lb_20", 1, 32'hFFFF_FFF0, 0);
    applyStimulus(0, SZ_BYTE, 1, 32'h20, 0); idle();
    checkLit("lbu_20", 1, 32'h0000_00F0, 0);
    applyStimulus(0, SZ_HALF, 0, 32'h20, 0); idle();
    checkLit("lh_20", 1, 32'hFFFF_80F0, 0);

    applyStimulus(1, SZ_HALF, 0, 32'h21, 32'h0000_FFFF); idle();
    checkLit("err_sh21", 1, 0, 1);
    applyStimulus(0, SZ_WORD, 0, 32'h22, 0); idle();
    checkLit("err_lw22", 1, 0, 1);
    applyStimulus(1, 2'b11, 0, 32'h20, 32'hFFFF_FFFF); idle();
    checkLit("err_sz11", 1, 0, 1);
    applyStimulus(1, SZ_WORD, 0, 32'h100, 32'h1234_5678); idle();
    checkLit("err_a100", 1, 0, 1);
    applyStimulus(0, SZ_WORD, 0, 32'h20, 0); idle();
    checkLit("keep_20", 1, 32'h0000_80F0, 0);
    applyStimulus(0, SZ_WORD, 0, 32'h00, 0); idle();
    checkLit("keep_00", 1, 32'h8000_00FF, 0);

    applyStimulus(1, SZ_HALF, 0, 32'h22, 32'h0000_BEEF);
    applyStimulus(0, SZ_HALF, 1, 32'h22, 0); idle();
    checkLit("lhu_22", 1, 32'h0000_BEEF, 0);
    applyStimulus(0, SZ_HALF, 0, 32'h22, 0); idle();
    checkLit("lh_22", 1, 32'hFFFF_BEEF, 0);

    applyStimulus(1, SZ_WORD, 0, 32'h08, 32'hDEAD_BEEF);
    applyStimulus(0, SZ_WORD, 0, 32'h08, 0);
    checkLit("b2b_st", 1, 0, 0);
    idle();
    checkLit("b2b_ld", 1, 32'hDEAD_BEEF, 0);

    // A request coinciding with reset must leave no response behind.
    applyStimulus(0, SZ_WORD, 0, 32'h20, 0);
    rst = 1;
    idle();
    rst = 0;
    checkLit("rst_drop", 0, 0, 0);
    repeat (30) @(negedge clk);
    rst = 1;
    req_valid = 1; req_we = 0; req_size = SZ_WORD; req_addr = 32'h0;
    @(negedge clk);
    rst = 0;
    measureInit("reinit_len");
    req_valid = 0;
    applyStimulus(0, SZ_WORD, 0, 32'h20, 0); idle();
    checkLit("reinit_20", 1, 32'h8000_00FF, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words; SHALL be a power of two, at least 4.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter INIT_VAL, default 32'h8000_00FF, value written to every word during initialisation.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_addr  input  ADDR_W  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid  output  1  response for the request accepted on the previous cycle.
REQ-014 rsp_rdata  output  32  load result, already extended.
REQ-015 rsp_err  output  1  accepted request was misaligned, out of range or illegal-size.
REQ-016 init_busy  output  1  initialisation sweep in progress.

Function
REQ-017 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT with init_cnt = 0.
REQ-018 In INIT the block SHALL write INIT_VAL to word init_cnt every cycle and then increment init_cnt; after the write to word DEPTH-1 it SHALL move to RUN, so INIT lasts exactly DEPTH cycles.
REQ-019 init_busy SHALL be 1 in INIT and 0 in RUN; req_ready SHALL equal !init_busy.
REQ-020 A request SHALL be accepted only when req_valid && req_ready; requests presented in INIT SHALL be ignored without a response.
REQ-021 Word index SHALL be req_addr[log2(DEPTH)+1:2] and byte lane SHALL be req_addr[1:0].
REQ-022 An error SHALL be flagged for req_size = 11, for a half access with addr[0] = 1, for a word access with addr[1:0] != 0, or when any address bit above log2(DEPTH)+1 is set.
REQ-023 An erroring request SHALL NOT modify memory.
REQ-024 A legal store SHALL write only the addressed lanes at the accepting edge: a byte store writes wdata[7:0] to one lane, a half store writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}, and a word store writes all four lanes.
REQ-025 Every accepted request SHALL produce exactly one response, with rsp_valid = 1 on the following cycle; latency is fixed at 1 cycle and there is no backpressure on responses.
REQ-026 A load response SHALL carry the addressed byte, half or word from the array contents at the accepting edge, extended per req_unsigned (a word load ignores req_unsigned).
REQ-027 A store response and an error response SHALL drive rsp_rdata = 0; rsp_err SHALL be 1 only for an error response.
REQ-028 A load accepted on the cycle after a store to the same word SHALL return the newly stored data.
REQ-029 When rsp_valid = 0, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-030 On rst = 1 the block SHALL force rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state INIT and init_cnt = 0; init_busy SHALL be 1 and req_ready 0 from the following cycle.
REQ-031 rst asserted during INIT SHALL restart the sweep from word 0; rst asserted in RUN SHALL discard any pending response.
REQ-032 Memory contents SHALL be defined only through the INIT sweep; there is no array reset.

Structure
REQ-033 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state typedef and the default INIT_VAL.
REQ-034 Sub-module dmem_lane_align (combinational) SHALL perform store lane steering and byte-enable generation, plus load lane extraction and extension; data_mem_be instantiates it once.

Verification
REQ-035 rst for 1 cycle, then idle: init_busy = 1 for exactly 64 cycles, then a word load at 0x0FC returns 0x8000_00FF with rsp_err = 0.
REQ-036 Word store 0x1122_3344 at 0x10, then byte store 0xAA at 0x11, then load word 0x10: returns 0x1122_AA44.
REQ-037 With word 0x20 = 0x0000_80F0: signed byte load at 0x20 returns 0xFFFF_FFF0, unsigned returns 0x0000_00F0, and signed half load at 0x20 returns 0xFFFF_80F0.
REQ-038 Half store at 0x21, word load at 0x22, req_size 11, and address 0x100 (with DEPTH = 64): each gives rsp_err = 1 and rsp_rdata = 0, and a later load shows memory unchanged.
REQ-039 rst asserted at init_cnt = 30: the sweep restarts and init_busy stays 1 for a further 64 cycles; requests driven meanwhile get no response.
REQ-040 Back-to-back store 0xDEAD_BEEF at 0x08 then load 0x08 on the next cycle: the load returns 0xDEAD_BEEF, with rsp_valid high on both cycles.
